// File: rtl/timer_sequencer.sv
// timer_sequencer: Avalon-MM master turning start/stop/snapshot commands and timer irqs into ordered s1 register accesses
module timer_sequencer #(
  parameter bit IRQ_EN     = 1'b1,
  parameter int MIN_PERIOD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic        running,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        snap_valid,
  output logic [31:0] snap_value
);
  typedef enum logic [3:0] {IDLE, STOP_W, PL_W, PH_W, CTL_W, SP_W, SN_W, SN_L, SN_H, SN_C, ACK_W, ACK_H} state_t;
  state_t      state;
  logic        rst_done;
  logic        cont;
  logic [31:0] load;
  logic [15:0] snap_lo;
  logic        irq_act;
  logic [31:0] period_c;
  assign irq_act   = tmr_irq && IRQ_EN;
  assign cmd_ready = rst_done && state == IDLE && !irq_act;
  assign period_c  = (cmd_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cmd_period;
  // Sequencer: one state per bus access; bus outputs are registered for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rst_done <= 1'b0;
      cont <= 1'b0;
      load <= 32'd0;
      snap_lo <= 16'd0;
      {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b01, 3'd0, 16'd0};
      running <= 1'b0;
      tick <= 1'b0;
      tick_count <= 16'd0;
      snap_valid <= 1'b0;
      snap_value <= 32'd0;
    end else begin
      rst_done <= 1'b1;
      {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b01, 3'd0, 16'd0};
      tick <= 1'b0;
      snap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (irq_act) begin
            state <= ACK_W;
            {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd0, 16'h0000};
          end else if (cmd_valid && rst_done) begin
            case (cmd_op)
              2'd0: begin
                state <= STOP_W;
                load <= period_c - 32'd1;
                cont <= cmd_continuous;
                {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd1, 16'h0008};
              end
              2'd1: begin
                state <= SP_W;
                {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd1, 16'h0008};
              end
              2'd2: begin
                state <= SN_W;
                {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd4, 16'h0000};
              end
              default: state <= IDLE;
            endcase
          end
        end
        STOP_W: begin
          state <= PL_W;
          {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd2, load[15:0]};
        end
        PL_W: begin
          state <= PH_W;
          {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd3, load[31:16]};
        end
        PH_W: begin
          state <= CTL_W;
          {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b10, 3'd1, 13'd0, 1'b1, cont, IRQ_EN};
        end
        CTL_W: begin
          state <= IDLE;
          running <= 1'b1;
        end
        SP_W: begin
          state <= IDLE;
          running <= 1'b0;
        end
        SN_W: begin
          state <= SN_L;
          {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b11, 3'd4, 16'h0000};
        end
        SN_L: begin
          state <= SN_H;
          {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} <= {2'b11, 3'd5, 16'h0000};
        end
        SN_H: begin
          state <= SN_C;
          snap_lo <= tmr_readdata;
        end
        SN_C: begin
          state <= IDLE;
          snap_value <= {tmr_readdata, snap_lo};
          snap_valid <= 1'b1;
        end
        ACK_W: begin
          state <= ACK_H;
          tick <= 1'b1;
          tick_count <= tick_count + 16'd1;
          if (!cont) running <= 1'b0;
        end
        ACK_H: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: interval-timer model plus bus/tick scoreboard around timer_sequencer
module tb_timer_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_continuous = 1'b0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  logic        running;
  logic        tick;
  logic [15:0] tick_count;
  logic        snap_valid;
  logic [31:0] snap_value;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acks_due = 0;
  int acks_seen = 0;
  int ticks_seen = 0;
  int last_tick = 0;
  logic [15:0] adj = 16'd0;
  logic [19:0] exp_bus[$];
  logic [19:0] m_e;
  logic [19:0] m_got;
  logic [15:0] m_pl, m_ph;
  logic [31:0] m_cnt, m_snap;
  logic        m_run, m_to, m_ito, m_cont;

  timer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq), .running(running), .tick(tick),
    .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer s1 model: registered readdata, irq one cycle behind the TO flag
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pl <= 16'd0; m_ph <= 16'd0; m_cnt <= 32'd0; m_snap <= 32'd0;
      m_run <= 1'b0; m_to <= 1'b0; m_ito <= 1'b0; m_cont <= 1'b0;
      tmr_readdata <= 16'd0; tmr_irq <= 1'b0;
    end else begin
      if (tmr_chipselect && !tmr_write_n) begin
        if (tmr_address == 3'd0) m_to <= 1'b0;
        if (tmr_address == 3'd1) begin
          m_ito <= tmr_writedata[0];
          m_cont <= tmr_writedata[1];
          if (tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= {m_ph, m_pl}; end
          if (tmr_writedata[3]) m_run <= 1'b0;
        end
        if (tmr_address == 3'd2) m_pl <= tmr_writedata;
        if (tmr_address == 3'd3) m_ph <= tmr_writedata;
        if (tmr_address == 3'd4 || tmr_address == 3'd5) m_snap <= m_cnt;
      end
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_to <= 1'b1;
          m_cnt <= {m_ph, m_pl};
          if (!m_cont) m_run <= 1'b0;
        end else m_cnt <= m_cnt - 32'd1;
      end
      tmr_readdata <= tmr_address == 3'd4 ? m_snap[15:0] : tmr_address == 3'd5 ? m_snap[31:16] : {14'd0, m_run, m_to};
      tmr_irq <= m_to && m_ito;
      if (m_to && m_ito && !tmr_irq) acks_due <= acks_due + 1;
    end
  end

  // Scoreboard: pops expected bus accesses, matches irq acks against model irqs, checks tick_count
  initial forever begin
    @(negedge clk);
    if (reset_n && tmr_chipselect) begin
      checks++;
      if (!tmr_write_n && tmr_address == 3'd0) begin
        if (acks_seen >= acks_due || tmr_writedata !== 16'h0000) begin
          errors++;
          $display("FAIL ack_write got data=%h acks_seen=%0d required data=0000 acks_due=%0d", tmr_writedata, acks_seen, acks_due);
        end
        acks_seen++;
      end else begin
        m_got = {tmr_write_n, tmr_address, tmr_write_n ? 16'h0000 : tmr_writedata};
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected got wr_n=%b addr=%0d data=%h", m_got[19], m_got[18:16], m_got[15:0]);
        end else begin
          m_e = exp_bus.pop_front();
          if (m_got !== m_e) begin
            errors++;
            $display("FAIL bus_access got wr_n=%b addr=%0d data=%h required wr_n=%b addr=%0d data=%h",
                     m_got[19], m_got[18:16], m_got[15:0], m_e[19], m_e[18:16], m_e[15:0]);
          end
        end
      end
    end
    if (reset_n && tick) begin
      checks++;
      if (tick_count !== 16'(16'(ticks_seen + 1) + adj)) begin
        errors++;
        $display("FAIL tick_count got=%h required=%h", tick_count, 16'(16'(ticks_seen + 1) + adj));
      end
      ticks_seen++;
      last_tick = cyc;
    end
  end

  task automatic push(input logic wr, input logic [2:0] a, input logic [15:0] d);
    exp_bus.push_back({~wr, a, wr ? d : 16'h0000});
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic cont);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_continuous = cont;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept op=%0d got cmd_ready=%b required 1", op, cmd_ready);
    end else @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 32'd0; cmd_continuous = 1'b0;
  endtask

  task automatic wait_tick(output int t);
    int n, s;
    n = 0;
    s = ticks_seen;
    while (ticks_seen == s && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (ticks_seen == s) begin
      errors++;
      $display("FAIL tick_timeout got no tick required one within 400 cycles");
    end
    t = last_tick;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, tmr_write_n, tmr_chipselect, running, tick, snap_valid, tick_count} !== {6'b010000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b wr_n=%b cs=%b run=%b tick=%b sv=%b tc=%h required 0 1 0 0 0 0 0000",
               cmd_ready, tmr_write_n, tmr_chipselect, running, tick, snap_valid, tick_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", cmd_ready); end
    checks++;
    if ({tmr_write_n, tmr_chipselect, tmr_address, tmr_writedata} !== {2'b10, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL idle_bus got wr_n=%b cs=%b addr=%0d data=%h required 1 0 0 0000", tmr_write_n, tmr_chipselect, tmr_address, tmr_writedata);
    end
  endtask

  task automatic test_start_periodic;
    int t0, t1, t2;
    push(1, 3'd1, 16'h0008); push(1, 3'd2, 16'h0063); push(1, 3'd3, 16'h0000); push(1, 3'd1, 16'h0007);
    issue(2'd0, 32'd100, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_bus.size() != 0) begin errors++; $display("FAIL periodic_seq got %0d pending required 0", exp_bus.size()); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL periodic_running got=%b required=1", running); end
    wait_tick(t0); wait_tick(t1); wait_tick(t2);
    checks++;
    if (t1 - t0 != 100) begin errors++; $display("FAIL tick_interval1 got=%0d required=100", t1 - t0); end
    checks++;
    if (t2 - t1 != 100) begin errors++; $display("FAIL tick_interval2 got=%0d required=100", t2 - t1); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL periodic_still_running got=%b required=1", running); end
    push(1, 3'd1, 16'h0008);
    issue(2'd1, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_running got=%b required=0", running); end
  endtask

  task automatic test_start_large;
    push(1, 3'd1, 16'h0008); push(1, 3'd2, 16'hFFFF); push(1, 3'd3, 16'h0001); push(1, 3'd1, 16'h0005);
    issue(2'd0, 32'h0002_0000, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL large_running got=%b required=1", running); end
    push(1, 3'd1, 16'h0008);
    issue(2'd1, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL large_stop got=%b required=0", running); end
  endtask

  task automatic test_snapshot;
    push(1, 3'd1, 16'h0008); push(1, 3'd2, 16'h869F); push(1, 3'd3, 16'h0001); push(1, 3'd1, 16'h0007);
    issue(2'd0, 32'd100000, 1'b1);
    repeat (4) @(negedge clk);
    push(1, 3'd4, 16'h0000); push(0, 3'd4, 16'h0000); push(0, 3'd5, 16'h0000);
    issue(2'd2, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (snap_valid !== (i == 4)) begin errors++; $display("FAIL snap_valid_cycle%0d got=%b required=%b", i, snap_valid, i == 4); end
    end
    checks++;
    if (snap_value !== 32'h0001_869E) begin errors++; $display("FAIL snap_value got=%h required=0001869e", snap_value); end
    push(1, 3'd1, 16'h0008);
    issue(2'd1, 32'd0, 1'b0);
  endtask

  task automatic test_clamp_oneshot;
    int s, t;
    s = ticks_seen;
    push(1, 3'd1, 16'h0008); push(1, 3'd2, 16'h0001); push(1, 3'd3, 16'h0000); push(1, 3'd1, 16'h0005);
    issue(2'd0, 32'd1, 1'b0);
    wait_tick(t);
    @(negedge clk);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL oneshot_running got=%b required=0", running); end
    repeat (50) @(negedge clk);
    checks++;
    if (ticks_seen != s + 1) begin errors++; $display("FAIL oneshot_ticks got=%0d required=%0d", ticks_seen - s, 1); end
  endtask

  task automatic test_reserved;
    issue(2'd3, 32'hDEAD_BEEF, 1'b1);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reserved_ready got=%b required=1", cmd_ready); end
    repeat (5) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reserved_running got=%b required=0", running); end
  endtask

  task automatic test_back_to_back_irq;
    int n, s;
    @(negedge clk);
    force dut.tick_count = 16'hFFFF;
    adj = 16'hFFFF - 16'(ticks_seen);
    @(negedge clk);
    release dut.tick_count;
    @(negedge clk);
    checks++;
    if (tick_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got=%h required=ffff", tick_count); end
    s = ticks_seen;
    push(1, 3'd1, 16'h0008); push(1, 3'd2, 16'h0013); push(1, 3'd3, 16'h0000); push(1, 3'd1, 16'h0005);
    issue(2'd0, 32'd20, 1'b0);
    n = 0;
    while (!tmr_irq && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tmr_irq !== 1'b1) begin errors++; $display("FAIL irq_timeout got irq=%b required 1", tmr_irq); return; end
    push(1, 3'd1, 16'h0008);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL irq_ready_n0 got=%b required=0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL irq_ready_ackw got=%b required=0", cmd_ready); end
    @(negedge clk);
    checks++;
    if ({cmd_ready, tick, tick_count} !== {2'b01, 16'h0000}) begin
      errors++;
      $display("FAIL irq_ackh got ready=%b tick=%b tc=%h required 0 1 0000", cmd_ready, tick, tick_count);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL irq_ready_after got=%b required=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0;
    repeat (10) @(negedge clk);
    checks++;
    if (ticks_seen != s + 1 || tick_count !== 16'h0000) begin
      errors++;
      $display("FAIL irq_single_tick got ticks=%0d tc=%h required 1 0000", ticks_seen - s, tick_count);
    end
  endtask

  initial begin
    test_reset();
    test_start_periodic();
    test_start_large();
    test_snapshot();
    test_clamp_oneshot();
    test_reserved();
    test_back_to_back_irq();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_bus.size() != 0) begin errors++; $display("FAIL bus_leftover got=%0d required=0", exp_bus.size()); end
    checks++;
    if (acks_seen != acks_due) begin errors++; $display("FAIL ack_balance got=%0d required=%0d", acks_seen, acks_due); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
